alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and destination-register width at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 alu_op  input  3  operation code, per REQ-012.
REQ-007 in1, in2  input  32 each  operands.
REQ-008 in_rd  input  5  destination register tag, carried unchanged with the result.
REQ-009 flush  input  1  synchronous discard of all held entries.
REQ-010 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-011 result (32), zero (1), illegal (1), out_rd (5)  outputs  data of the head entry.

Function
REQ-012 Operation codes:
- 000 = AND (bitwise 32-bit).
- 001 = OR (bitwise 32-bit).
- 010 = ADD (modulo 2^32, carry discarded).
- 110 = SUB (in1 - in2, modulo 2^32).
- 111 = SLT (signed two's-complement compare; result 32'h1 if in1 < in2, else 32'h0).
- 011 = NOR (bitwise 32-bit).
- 100 and 101: result = 0 and illegal = 1.
REQ-013 zero SHALL be 1 exactly when the stored result equals 32'h0, including for illegal ops.
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 The result SHALL be computed combinationally from in1, in2 and alu_op and registered at the input transfer, giving an accept-to-out_valid latency of exactly 1 cycle when the buffer was empty.
REQ-016 Storage SHALL be a 2-entry in-order skid buffer with states EMPTY, ONE and TWO.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, and SHALL be registered state only, with no combinational dependence on out_ready.
REQ-018 out_valid SHALL be 1 in ONE and TWO; result, zero, illegal and out_rd SHALL always present the oldest entry.
REQ-019 State transitions:
- EMPTY + push -> ONE.
- ONE + push and no pop -> TWO.
- ONE + pop and no push -> EMPTY.
- ONE + simultaneous push and pop -> ONE; the new entry becomes the head.
- TWO + pop -> ONE; the second entry moves to the head.
- All other cases hold the current state.
REQ-020 Outputs SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-021 flush = 1 SHALL, at the next edge, force EMPTY and discard all entries; an input offered in the same cycle SHALL be dropped, and a pop in the same cycle has no additional effect.
REQ-022 Entry contents SHALL be unaffected when no transfer occurs; no entry is ever duplicated or reordered.

Reset
REQ-023 While rst_n = 0, state SHALL be EMPTY and outputs SHALL be: out_valid = 0, in_ready = 0, result = 0, zero = 1, illegal = 0, out_rd = 0.
REQ-024 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously to clk.

Verification
REQ-026 OR path: push op = 001, in1 = 32'hF0F0_0000, in2 = 32'h0F0F_00FF, out_ready = 1 -> next cycle out_valid = 1, result = 32'hFFFF_00FF, zero = 0.
REQ-027 SLT and SUB: push SLT with in1 = 32'hFFFF_FFFF, in2 = 1 -> result = 1; push SUB with 5, 5 -> result = 0 and zero = 1.
REQ-028 Backpressure: out_ready = 0 while pushing ADD 1+2, then ADD 3+4 -> state TWO, in_ready = 0, head result = 3; raise out_ready -> results 3 then 7 in order with no loss.
REQ-029 Simultaneous push and pop in ONE over 10 back-to-back ops -> throughput of 1 op per cycle, in_ready held at 1, out_rd sequence matches the input sequence.
REQ-030 Flush with two entries held plus a concurrent push -> next cycle out_valid = 0, state EMPTY, pushed op never appears at the output.
REQ-031 Async reset pulse while in TWO -> out_valid = 0 without a clock edge; illegal op 100 afterwards -> result = 0, illegal = 1, zero = 1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage feeding a 2-entry in-order skid buffer.
// Result flags are computed at accept time and stored with the destination tag.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal,
  output logic [4:0]  out_rd
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
    logic [RD_W-1:0]   rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam entry_t ENTRY_RST = '{result: '0, zero: 1'b1, illegal: 1'b0, rd: '0};

  state_t state, state_nxt;
  entry_t head, head_nxt;
  entry_t second, second_nxt;
  entry_t new_entry;
  logic   push_c, pop_c;

  // Combinational ALU producing the entry to store on accept.
  always_comb begin
    new_entry         = ENTRY_RST;
    new_entry.rd      = in_rd;
    case (alu_op)
      3'b000: new_entry.result = in1 & in2;
      3'b001: new_entry.result = in1 | in2;
      3'b010: new_entry.result = in1 + in2;
      3'b011: new_entry.result = ~(in1 | in2);
      3'b110: new_entry.result = in1 - in2;
      3'b111: new_entry.result = DATA_W'($signed(in1) < $signed(in2));
      default: begin
        new_entry.result  = '0;
        new_entry.illegal = 1'b1;
      end
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  // A push offered alongside flush is dropped.
  assign push_c = in_valid && in_ready && !flush;
  assign pop_c  = out_valid && out_ready;

  always_comb begin
    state_nxt  = state;
    head_nxt   = head;
    second_nxt = second;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push_c) begin
            state_nxt = ONE;
            head_nxt  = new_entry;
          end
        end
        ONE: begin
          if (push_c && pop_c) begin
            head_nxt = new_entry;
          end else if (push_c) begin
            state_nxt  = TWO;
            second_nxt = new_entry;
          end else if (pop_c) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop_c) begin
            state_nxt = ONE;
            head_nxt  = second;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= ENTRY_RST;
      second    <= ENTRY_RST;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      head      <= head_nxt;
      second    <= second_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != TWO);
    end
  end

  assign result  = head.result;
  assign zero    = head.zero;
  assign illegal = head.illegal;
  assign out_rd  = head.rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: a vector table for the ALU function plus
// hand-written sequences for backpressure, streaming, flush and async reset.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [31:0] in1, in2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, illegal;
  logic [4:0]  out_rd;

  int n_vec  = 0;
  int n_fail = 0;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .in1(in1), .in2(in2), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    alu_op   = op;
    in1      = a;
    in2      = b;
    in_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};
    vecs[4]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[6]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{3'b011, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{3'b100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b1};
    vecs[12] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; alu_op = 3'b000; in1 = '0; in2 = '0;
    in_rd = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset values, then in_ready rising on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_result",    result,         32'd0);
    chk("rst_zero",      32'(zero),      32'd1);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_out_rd",    32'(out_rd),    32'd0);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);
    chk("out_valid_idle", 32'(out_valid), 32'd0);

    // Table: one op at a time from EMPTY, one-cycle latency, then popped.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      offer(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
      tick();
      in_valid = 1'b0;
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_result",    result,         vecs[i].exp_res);
      chk("vec_zero",      32'(zero),      32'(vecs[i].exp_zero));
      chk("vec_illegal",   32'(illegal),   32'(vecs[i].exp_ill));
      chk("vec_out_rd",    32'(out_rd),    32'(i + 1));
      tick();
      chk("vec_drained", 32'(out_valid), 32'd0);
    end

    // Backpressure: two entries held, stable, then drained in order.
    out_ready = 1'b0;
    offer(3'b010, 32'd1, 32'd2, 5'd1);
    tick();
    offer(3'b010, 32'd3, 32'd4, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready",  32'(in_ready),  32'd0);
    chk("bp_head",      result,         32'd3);
    tick();
    chk("bp_stable_res", result,        32'd3);
    chk("bp_stable_rd",  32'(out_rd),   32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_res", result,         32'd7);
    chk("bp_second_rd",  32'(out_rd),    32'd2);
    chk("bp_in_ready1",  32'(in_ready),  32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Streaming: push and pop every cycle.
    for (int i = 0; i < 10; i++) begin
      offer(3'b010, 32'(i), 32'd100, 5'(10 + i));
      tick();
      chk("st_out_valid", 32'(out_valid), 32'd1);
      chk("st_in_ready",  32'(in_ready),  32'd1);
      chk("st_out_rd",    32'(out_rd),    32'(10 + i));
      chk("st_result",    result,         32'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("st_drained", 32'(out_valid), 32'd0);

    // Flush with two held entries and an input offered.
    out_ready = 1'b0;
    offer(3'b001, 32'h1, 32'h0, 5'd3);
    tick();
    offer(3'b001, 32'h2, 32'h0, 5'd4);
    tick();
    offer(3'b001, 32'h3, 32'h0, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_in_ready",  32'(in_ready),  32'd1);
    // Flush in ONE where the offered op would otherwise be accepted.
    offer(3'b001, 32'h4, 32'h0, 5'd6);
    tick();
    offer(3'b001, 32'h5, 32'h0, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl1_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    offer(3'b001, 32'h6, 32'h0, 5'd8);
    tick();
    in_valid = 1'b0;
    chk("fl_recover_rd",  32'(out_rd), 32'd8);
    chk("fl_recover_res", result,      32'h6);
    tick();

    // Async reset while holding two entries, then an illegal op.
    out_ready = 1'b0;
    offer(3'b010, 32'd1, 32'd1, 5'd1);
    tick();
    offer(3'b010, 32'd2, 32'd2, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd0);
    chk("ar_result",    result,         32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_in_ready_up", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    offer(3'b100, 32'd5, 32'd9, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("ill_out_valid", 32'(out_valid), 32'd1);
    chk("ill_result",    result,         32'd0);
    chk("ill_illegal",   32'(illegal),   32'd1);
    chk("ill_zero",      32'(zero),      32'd1);
    chk("ill_out_rd",    32'(out_rd),    32'd9);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
